// File: rtl/alu_multicycle_pkg.sv
// Shared ALU definitions: Sel codes, FSM state encodings and overflow helpers.
// Imported by alu_multicycle and seq_divider (also used by ALU control).
package alu_multicycle_pkg;

  localparam logic [3:0] ALU_ADD0 = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // Signed overflow from operand and result sign bits.
  function automatic logic add_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic r_msb
  );
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic r_msb
  );
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_multicycle_seq_divider.sv
// seq_divider: signed restoring divider, quotient truncated toward zero.
// Ports: clk, reset (sync, active-high), start, dividend, divisor,
//   done (high in the sign-fix cycle), quotient (valid while done).
// Latency: start edge, WIDTH iteration edges, then one sign-fix cycle.
module seq_divider
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Magnitude of the most negative value is itself as unsigned,
  // which makes MIN / -1 wrap back to MIN after the sign fix.
  assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
  assign mag_b = divisor[WIDTH-1] ? -divisor : divisor;

  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign fits   = ~diff[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      neg  <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quo  <= mag_a;
      dvs  <= mag_b;
      neg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
    end else if (busy) begin
      if (cnt == CW'(WIDTH)) begin
        busy <= 1'b0;
      end else begin
        rem <= fits ? diff : rem_sh;
        quo <= {quo[WIDTH-2:0], fits};
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign done     = busy && (cnt == CW'(WIDTH));
  assign quotient = neg ? -quo : quo;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt, iterative MUL and DIV.
// Ports: clk, reset (sync, active-high), in_valid/in_ready, Sel, A, B,
//   out_valid (1-cycle pulse), Result, Zero; Overflow when ALU_OVERFLOW_EN.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic [WIDTH-1:0] mul_next;

  logic             accept;
  logic             b_zero;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] sc_res;
`ifdef ALU_OVERFLOW_EN
  logic             sc_ovf;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign b_zero    = (B == '0);
  assign div_start = accept && (Sel == ALU_DIV) && !b_zero;

  assign sum = A + B;
  assign dif = A - B;

  always_comb begin
    sc_res = '0;
    unique case (Sel)
      ALU_ADD0, ALU_ADD: sc_res = sum;
      ALU_SUB: sc_res = dif;
      ALU_DIV: sc_res = '1;
      ALU_AND: sc_res = A & B;
      ALU_OR:  sc_res = A | B;
      ALU_NOR: sc_res = ~(A | B);
      ALU_SLT: sc_res = {{(WIDTH-1){1'b0}},
                         $signed(A) < $signed(B)};
      ALU_XOR: sc_res = A ^ B;
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    sc_ovf = 1'b0;
    unique case (Sel)
      ALU_ADD0, ALU_ADD:
        sc_ovf = add_ovf(A[WIDTH-1], B[WIDTH-1], sum[WIDTH-1]);
      ALU_SUB:
        sc_ovf = sub_ovf(A[WIDTH-1], B[WIDTH-1], dif[WIDTH-1]);
      default: sc_ovf = 1'b0;
    endcase
  end
`endif

  // Shift-add step; the last step is registered straight into Result.
  assign mul_next = mul_mplier[0] ? mul_acc + mul_mcand : mul_acc;

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (A),
    .divisor  (B),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      out_valid  <= 1'b0;
      Result     <= '0;
      Zero       <= 1'b1;
`ifdef ALU_OVERFLOW_EN
      Overflow   <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (Sel == ALU_MUL) begin
              state      <= ST_MUL;
              cnt        <= '0;
              mul_acc    <= '0;
              mul_mcand  <= A;
              mul_mplier <= B;
            end else if (div_start) begin
              state <= ST_DIV;
            end else begin
              Result    <= sc_res;
              Zero      <= (sc_res == '0);
              out_valid <= 1'b1;
`ifdef ALU_OVERFLOW_EN
              Overflow  <= sc_ovf;
`endif
            end
          end
        end
        ST_MUL: begin
          mul_acc    <= mul_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          cnt        <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= ST_IDLE;
            Result    <= mul_next;
            Zero      <= (mul_next == '0);
            out_valid <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            Overflow  <= 1'b0;
`endif
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state     <= ST_IDLE;
            Result    <= div_q;
            Zero      <= (div_q == '0);
            out_valid <= 1'b1;
`ifdef ALU_OVERFLOW_EN
            Overflow  <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed vectors, timing-checked.
// Overflow is checked when ALU_OVERFLOW_EN is defined.
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Sel = 4'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic [31:0] Result;
  logic        Zero;
`ifdef ALU_OVERFLOW_EN
  logic        Overflow;
`endif

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sel       (Sel),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Result    (Result),
    .Zero      (Zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .Overflow  (Overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out_valid cyc=%0d got=%h required=none",
                 cyc, Result);
      end else begin
        logic bad;
        mon_e = sb.pop_front();
        bad = (Result !== mon_e.res) || (Zero !== mon_e.zero) ||
              (cyc != mon_e.due);
`ifdef ALU_OVERFLOW_EN
        bad = bad || (Overflow !== mon_e.ovf);
`endif
        if (bad) begin
          fails++;
          $display("FAIL %s got res=%h zero=%b cyc=%0d required res=%h zero=%b cyc=%0d",
                   mon_e.name, Result, Zero, cyc,
                   mon_e.res, mon_e.zero, mon_e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic issue(input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input logic ovf, input int lat, input string name);
    exp_t e;
    int guard = 0;
    @(posedge clk); #1;
    while (!in_ready && guard < 200) begin
      in_valid = 1'b0;
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout got=0 required=1", name);
    end
    Sel = s;
    A = a;
    B = b;
    in_valid = 1'b1;
    e.res = res;
    e.zero = (res == 32'h0);
    e.ovf = ovf;
    e.due = cyc + lat;
    e.name = name;
    sb.push_back(e);
  endtask

  // Holds a junk request during the busy window, counts in_ready-low cycles.
  task automatic busy_check(input int req, input string name);
    int busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (in_ready) break;
      busy++;
      Sel = ALU_ADD;
      A = 32'h1;
      B = 32'h1;
    end
    in_valid = 1'b0;
    chk(name, busy, req);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout got=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_result", Result, 32'h0);
    chk("reset_zero", {31'b0, Zero}, 32'h1);
    chk("reset_ready", {31'b0, in_ready}, 32'h1);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);

    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1, "add_ovf");
    idle();
    issue(ALU_SUB, 32'h5, 32'h5, 32'h0, 1'b0, 1, "sub_zero");
    issue(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 1, "xor");
    issue(ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1, "and");
    issue(ALU_OR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1, "or");
    issue(ALU_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, "nor");
    issue(ALU_ADD0, 32'h2, 32'h3, 32'h5, 1'b0, 1, "add0");
    issue(ALU_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1, "sub_neg");
    issue(ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1, "sub_ovf");
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1, "slt_true");
    issue(ALU_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, "slt_false");
    issue(4'b1100, 32'h1234, 32'h5678, 32'h0, 1'b0, 1, "undef_sel");
    idle();
    drain();

    issue(ALU_MUL, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 1'b0, 33, "mul_neg");
    busy_check(32, "mul_busy_cycles");
    issue(ALU_MUL, 32'd12345, 32'd1000, 32'h00BC_5EA8, 1'b0, 33, "mul_pos");
    issue(ALU_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1, "add_after_mul");
    idle();
    drain();

    issue(ALU_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1'b0, 34, "div_neg");
    busy_check(33, "div_busy_cycles");
    issue(ALU_DIV, 32'h9, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, "div_by_zero");
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34, "div_wrap");
    issue(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 34, "div_100_m7");
    idle();
    drain();

    issue(ALU_MUL, 32'h5, 32'h5, 32'h19, 1'b0, 33, "mul_aborted");
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_result", Result, 32'h0);
    chk("abort_zero", {31'b0, Zero}, 32'h1);
    chk("abort_ready", {31'b0, in_ready}, 32'h1);
    chk("abort_valid", {31'b0, out_valid}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    issue(ALU_ADD, 32'h1, 32'h1, 32'h2, 1'b0, 1, "add_after_abort");
    idle();
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
